// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 4-digit common-anode 7-segment scanner with frame-latched shadows
// Optional leading-zero blanking is enabled by defining FND_LZB_EN.
module fnd_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  digit_en,
  output logic [3:0]  com,
  output logic [7:0]  seg,
  output logic [1:0]  cur_digit,
  output logic        frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;
  localparam logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cur_q, cur_d;
  logic [15:0]   val_q, val_d;
  logic [3:0]    dp_q, dp_d, en_q, en_d;
  logic [3:0]    com_q, com_d;
  logic [7:0]    seg_q, seg_d;
  logic          fd_q, fd_d;
  logic          wrap, load, guard_next, lz, lit;
  logic [3:0]    nib;
  always_comb begin
    wrap       = state_q != S_IDLE && cnt_q == LAST;
    load       = enable && (state_q == S_IDLE || (wrap && cur_q == 2'd3));
    guard_next = BLANK_CYCLES != 0 && int'(cnt_q) + 1 >= SCAN_DIV - BLANK_CYCLES;
    state_d    = !enable ? S_IDLE : (state_q == S_IDLE || wrap) ? S_DRIVE :
                 guard_next ? S_GUARD : state_q;
    cnt_d      = (!enable || state_q == S_IDLE || wrap) ? '0 : cnt_q + CW'(1);
    cur_d      = (!enable || state_q == S_IDLE) ? 2'd0 : wrap ? cur_q + 2'd1 : cur_q;
    val_d      = load ? value : val_q;
    dp_d       = load ? dp : dp_q;
    en_d       = load ? digit_en : en_q;
    fd_d       = enable && wrap && cur_q == 2'd3;
    nib        = 4'(val_q >> {cur_q, 2'b00});
`ifdef FND_LZB_EN
    lz         = cur_q != 2'd0 && (val_q >> {cur_q, 2'b00}) == 16'h0 && !dp_q[cur_q];
`else
    lz         = 1'b0;
`endif
    // outputs follow the pre-edge state, so they trail the FSM by one cycle
    lit        = state_q == S_DRIVE && en_q[cur_q] && !lz;
    com_d      = lit ? ~(4'b0001 << cur_q) : 4'hF;
    seg_d      = lit ? {~dp_q[cur_q], ~HEX7[nib]} : 8'hFF;
  end
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cur_q   <= 2'd0;
      val_q   <= 16'h0;
      dp_q    <= 4'h0;
      en_q    <= 4'h0;
      com_q   <= 4'hF;
      seg_q   <= 8'hFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      com_q   <= com_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end
  assign com        = com_q;
  assign seg        = seg_q;
  assign cur_digit  = cur_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: directed bench with a cycle-count model of the FND scanner
module tb_fnd_scan_ctrl;
  localparam int SD = 8;
  localparam int BC = 2;
  logic        clk = 1'b0;
  logic        reset_p, enable;
  logic [15:0] value;
  logic [3:0]  dp, digit_en, com;
  logic [7:0]  seg;
  logic [1:0]  cur_digit;
  logic        frame_done;
  int checks = 0, errors = 0, st = 0;
  fnd_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset_p(reset_p), .enable(enable), .value(value), .dp(dp),
    .digit_en(digit_en), .com(com), .seg(seg), .cur_digit(cur_digit), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask
  // model: a running cycle index since scanning began; slot/position follow by division
  logic [6:0]  hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit          m_valid = 0, m_run = 0;
  int          m_t = 0;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_en, e_com;
  logic [7:0]  e_seg;
  logic [1:0]  e_cur;
  logic        e_fd;
  function automatic logic [11:0] model_out();
    int  slot = (m_t / SD) % 4;
    int  pos = m_t % SD;
    bit  lit = m_run && pos < SD - BC && m_en[slot];
`ifdef FND_LZB_EN
    if (slot > 0 && (m_val >> (4 * slot)) == 0 && !m_dp[slot]) lit = 0;
`endif
    return lit ? {4'(~(1 << slot)), ~m_dp[slot], ~hex7[4'(m_val >> (4 * slot))]} : 12'hFFF;
  endfunction
  always @(posedge clk) begin
    if (reset_p) begin
      m_valid = 1; m_run = 0; m_t = 0;
      m_val = 0; m_dp = 0; m_en = 0;
      {e_com, e_seg} = 12'hFFF; e_cur = 0; e_fd = 0;
    end else begin
      {e_com, e_seg} = model_out();
      e_fd = 0;
      if (!enable) begin
        m_run = 0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1; m_t = 0;
        m_val = value; m_dp = dp; m_en = digit_en;
      end else begin
        m_t++;
        if (m_t % (4 * SD) == 0) begin
          m_val = value; m_dp = dp; m_en = digit_en; e_fd = 1;
        end
      end
      e_cur = m_run ? 2'((m_t / SD) % 4) : 2'd0;
    end
    #1;
    if (m_valid) begin
      chk("com", 32'(com), 32'(e_com));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("cur_digit", 32'(cur_digit), 32'(e_cur));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
    end
  end
  task automatic goto(input int k);
    repeat (k - st) @(posedge clk);
    st = k;
    @(negedge clk);
  endtask
  task automatic lit2(input string name, input logic [3:0] c, input logic [7:0] s);
    chk({name, "_com"}, 32'(com), 32'(c));
    chk({name, "_seg"}, 32'(seg), 32'(s));
  endtask
  initial begin
    reset_p = 1; enable = 1; value = 16'h1A0F; dp = 4'b0100; digit_en = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    lit2("reset", 4'hF, 8'hFF);
    chk("reset_cur", 32'(cur_digit), 0);
    chk("reset_fd", 32'(frame_done), 0);
    reset_p = 0;
    @(posedge clk); st = 0;
    goto(1);  lit2("slot0", 4'hE, 8'h8E); chk("slot0_cur", 32'(cur_digit), 0);
    goto(6);  lit2("slot0_last_drive", 4'hE, 8'h8E);
    goto(7);  lit2("slot0_guard", 4'hF, 8'hFF);
    goto(9);  lit2("slot1", 4'hD, 8'hC0); chk("slot1_cur", 32'(cur_digit), 1);
    goto(17); lit2("slot2", 4'hB, 8'h08);
    goto(25); lit2("slot3", 4'h7, 8'hF9);
    goto(31); chk("fd_before_wrap", 32'(frame_done), 0);
    goto(32); chk("fd_wrap", 32'(frame_done), 1); chk("wrap_cur", 32'(cur_digit), 0);
    goto(42); value = 16'h2222;
    goto(49); lit2("midframe_slot2", 4'hB, 8'h08);
    goto(57); lit2("midframe_slot3", 4'h7, 8'hF9);
    goto(64); chk("fd_frame2", 32'(frame_done), 1);
    goto(65); lit2("new_frame", 4'hE, 8'hA4);
    goto(70); digit_en = 4'b0101;
    goto(73); lit2("mask_pending", 4'hD, 8'hA4);
    goto(97); lit2("mask_slot0", 4'hE, 8'hA4);
    goto(105); lit2("mask_slot1", 4'hF, 8'hFF);
    goto(115); enable = 0;
    @(negedge clk);
    chk("disable_cur", 32'(cur_digit), 0);
    lit2("disable_lag", 4'hB, 8'h24);
    @(negedge clk);
    lit2("disable_dark", 4'hF, 8'hFF);
    value = 16'h0005; dp = 4'h0; digit_en = 4'hF; enable = 1;
    @(posedge clk); st = 0;
    goto(1); lit2("restart_slot0", 4'hE, 8'h92);
`ifdef FND_LZB_EN
    goto(9); lit2("lzb_slot1", 4'hF, 8'hFF);
`else
    goto(9); lit2("zero_slot1", 4'hD, 8'hC0);
`endif
    goto(12); value = 16'h0000;
    goto(33); lit2("zero_slot0", 4'hE, 8'hC0);
`ifdef FND_LZB_EN
    goto(41); lit2("lzb_zero_slot1", 4'hF, 8'hFF);
`else
    goto(41); lit2("zero_frame_slot1", 4'hD, 8'hC0);
`endif
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
